// File: rtl/eth_phy_mgmt_init.sv
// Brings an external Ethernet PHY out of reset, programs two Clause 22 registers over
// MDIO, then polls BMSR forever and reports link state on link_up / PL_LED1.
module eth_phy_mgmt_init #(
  parameter int unsigned MDC_DIV      = 25,
  parameter int unsigned RST_CYCLES   = 500000,
  parameter int unsigned POST_RST_CYC = 250000,
  parameter int unsigned POLL_CYCLES  = 5000000,
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [4:0]  CFG0_REG     = 5'd0,
  parameter logic [15:0] CFG0_DATA    = 16'h1140,
  parameter logic [4:0]  CFG1_REG     = 5'd4,
  parameter logic [15:0] CFG1_DATA    = 16'h01E1
) (
  input  logic clk,
  input  logic rst,
  output logic ETH_nRST,
  output logic ETH_MDIO_mdc,
  output logic ETH_MDIO_mdio_o,
  output logic ETH_MDIO_mdio_t,
  input  logic ETH_MDIO_mdio_i,
  output logic init_done,
  output logic link_up,
  output logic mdio_noack,
  output logic PL_LED1
);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    WR0,
    WR1,
    POLL_RD,
    POLL_GAP
  } state_t;

  localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] POST_LAST = 32'(POST_RST_CYC - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(MDC_DIV - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [15:0] div_reg, div_next;
  logic [5:0]  bit_reg, bit_next;
  logic        active_reg, active_next;
  logic        mdc_reg, mdc_next;
  logic        mdio_o_reg, mdio_o_next;
  logic        mdio_t_reg, mdio_t_next;
  logic        nrst_reg, nrst_next;
  logic        init_done_reg, init_done_next;
  logic        link_up_reg, link_up_next;
  logic        noack_reg, noack_next;
  logic [15:0] shift_reg, shift_next;
  logic        ta_reg, ta_next;

  logic [63:0] frame_word;
  logic        frame_is_read;

  function automatic logic [63:0] build_frame(input logic [1:0] op, input logic [4:0] regad,
                                              input logic [1:0] ta, input logic [15:0] data);
    return {32'hFFFF_FFFF, 2'b01, op, PHY_ADDR, regad, ta, data};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RST_HOLD;
      cnt_reg       <= '0;
      div_reg       <= '0;
      bit_reg       <= '0;
      active_reg    <= 1'b0;
      mdc_reg       <= 1'b0;
      mdio_o_reg    <= 1'b1;
      mdio_t_reg    <= 1'b1;
      nrst_reg      <= 1'b0;
      init_done_reg <= 1'b0;
      link_up_reg   <= 1'b0;
      noack_reg     <= 1'b0;
      shift_reg     <= '0;
      ta_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      div_reg       <= div_next;
      bit_reg       <= bit_next;
      active_reg    <= active_next;
      mdc_reg       <= mdc_next;
      mdio_o_reg    <= mdio_o_next;
      mdio_t_reg    <= mdio_t_next;
      nrst_reg      <= nrst_next;
      init_done_reg <= init_done_next;
      link_up_reg   <= link_up_next;
      noack_reg     <= noack_next;
      shift_reg     <= shift_next;
      ta_reg        <= ta_next;
    end
  end

  // Frame contents for the current state; reads leave TA/DATA as ones (line released).
  always_comb begin
    frame_word    = build_frame(2'b10, 5'd1, 2'b11, 16'hFFFF);
    frame_is_read = 1'b1;
    case (state_reg)
      WR0: begin
        frame_word    = build_frame(2'b01, CFG0_REG, 2'b10, CFG0_DATA);
        frame_is_read = 1'b0;
      end
      WR1: begin
        frame_word    = build_frame(2'b01, CFG1_REG, 2'b10, CFG1_DATA);
        frame_is_read = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    div_next       = div_reg;
    bit_next       = bit_reg;
    active_next    = active_reg;
    mdc_next       = mdc_reg;
    mdio_o_next    = mdio_o_reg;
    mdio_t_next    = mdio_t_reg;
    nrst_next      = nrst_reg;
    init_done_next = init_done_reg;
    link_up_next   = link_up_reg;
    noack_next     = 1'b0;
    shift_next     = shift_reg;
    ta_next        = ta_reg;

    case (state_reg)
      RST_HOLD: begin
        nrst_next = 1'b0;
        if (cnt_reg == RST_LAST) begin
          state_next = RST_WAIT;
          cnt_next   = '0;
          nrst_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      RST_WAIT: begin
        if (cnt_reg == POST_LAST) begin
          state_next  = WR0;
          cnt_next    = '0;
          active_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      POLL_GAP: begin
        if (cnt_reg == POLL_LAST) begin
          state_next  = POLL_RD;
          cnt_next    = '0;
          active_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      WR0, WR1, POLL_RD: begin
        if (!active_reg) begin
          // One idle cycle precedes every frame; this edge presents bit 0.
          active_next = 1'b1;
          div_next    = '0;
          bit_next    = '0;
          mdc_next    = 1'b0;
          mdio_o_next = frame_word[63];
          mdio_t_next = 1'b0;
        end else if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (!mdc_reg) begin
            mdc_next = 1'b1;
            if (frame_is_read && bit_reg == 6'd47) ta_next = ETH_MDIO_mdio_i;
            if (frame_is_read && bit_reg >= 6'd48) shift_next = {shift_reg[14:0], ETH_MDIO_mdio_i};
          end else begin
            mdc_next = 1'b0;
            if (bit_reg == 6'd63) begin
              active_next = 1'b0;
              bit_next    = '0;
              mdio_o_next = 1'b1;
              mdio_t_next = 1'b1;
              case (state_reg)
                WR0: state_next = WR1;
                WR1: begin
                  state_next     = POLL_RD;
                  init_done_next = 1'b1;
                end
                default: begin
                  state_next = POLL_GAP;
                  cnt_next   = '0;
                  if (ta_reg) begin
                    noack_next   = 1'b1;
                    link_up_next = 1'b0;
                  end else begin
                    link_up_next = shift_reg[2];
                  end
                end
              endcase
            end else begin
              bit_next    = bit_reg + 6'd1;
              mdio_o_next = frame_word[6'd62 - bit_reg];
              mdio_t_next = frame_is_read && (bit_reg >= 6'd45);
            end
          end
        end else begin
          div_next = div_reg + 16'd1;
        end
      end
      default: begin
        state_next = RST_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  assign ETH_nRST        = nrst_reg;
  assign ETH_MDIO_mdc    = mdc_reg;
  assign ETH_MDIO_mdio_o = mdio_o_reg;
  assign ETH_MDIO_mdio_t = mdio_t_reg;
  assign init_done       = init_done_reg;
  assign link_up         = link_up_reg;
  assign mdio_noack      = noack_reg;
  assign PL_LED1         = link_up_reg;

endmodule

// File: tb/tb_eth_phy_mgmt_init.sv
// Bench for eth_phy_mgmt_init: an MDIO PHY model answers BMSR reads from a randomized plan,
// and a frame-level reference predicts link_up / mdio_noack / init_done.
module tb_eth_phy_mgmt_init;

  localparam int MDC_DIV = 2;
  localparam int RST_C   = 20;
  localparam int POST_C  = 10;
  localparam int POLL_C  = 40;
  localparam int NPLAN   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eth_nrst, mdc, mdio_o, mdio_t, mdio_i;
  logic init_done, link_up, mdio_noack, pl_led1;

  always #5 clk = ~clk;

  eth_phy_mgmt_init #(
    .MDC_DIV(MDC_DIV), .RST_CYCLES(RST_C), .POST_RST_CYC(POST_C), .POLL_CYCLES(POLL_C)
  ) dut (
    .clk(clk), .rst(rst), .ETH_nRST(eth_nrst), .ETH_MDIO_mdc(mdc),
    .ETH_MDIO_mdio_o(mdio_o), .ETH_MDIO_mdio_t(mdio_t), .ETH_MDIO_mdio_i(mdio_i),
    .init_done(init_done), .link_up(link_up), .mdio_noack(mdio_noack), .PL_LED1(pl_led1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected frames built straight from the Clause 22 field layout.
  logic [63:0] exp_wr0 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140};
  logic [63:0] exp_wr1 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 16'h01E1};
  logic [45:0] exp_rd_hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd1};
  logic [63:0] exp_rd_t = {46'd0, 18'h3FFFF};

  logic        plan_resp[NPLAN];
  logic [15:0] plan_data[NPLAN];

  // Monitor / PHY model state
  int          rise_cnt = 0;
  int          frame_idx = 0;
  int          reads_done = 0;
  int          read_idx = 0;
  int          exp_noack = 0;
  int          noack_seen = 0;
  logic        model_link = 1'b0;
  logic        model_init = 1'b0;
  logic        is_read = 1'b0;
  logic        cur_resp = 1'b0;
  logic [15:0] cur_data = '0;
  logic [63:0] cur_o = '0, cur_t = '0;
  logic [63:0] cap_o[2], cap_t[2];
  logic        mdc_prev = 1'b0;

  initial begin
    mdio_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rise_cnt = 0; frame_idx = 0; model_link = 1'b0; model_init = 1'b0;
        is_read = 1'b0; mdc_prev = 1'b0; mdio_i = 1'b1;
      end else begin
        if (mdio_noack) noack_seen++;
        if (mdc && !mdc_prev) begin
          cur_o = {cur_o[62:0], mdio_o};
          cur_t = {cur_t[62:0], mdio_t};
          rise_cnt++;
          if (rise_cnt == 36) begin
            is_read = (cur_o[1:0] == 2'b10);
            if (is_read && read_idx < NPLAN) begin
              cur_resp = plan_resp[read_idx];
              cur_data = plan_data[read_idx];
            end else begin
              cur_resp = 1'b0;
              cur_data = 16'hFFFF;
            end
          end
        end else if (!mdc && mdc_prev) begin
          if (rise_cnt == 64) begin
            if (is_read) begin
              if (cur_resp) model_link = cur_data[2];
              else begin
                model_link = 1'b0;
                exp_noack++;
              end
              check_eq("rd_header", 64'(cur_o[63:18]), 64'(exp_rd_hdr));
              check_eq("rd_tristate", cur_t, exp_rd_t);
              check_eq("rd_end_link", 64'(link_up), 64'(model_link));
              check_eq("rd_end_led", 64'(pl_led1), 64'(model_link));
              check_eq("rd_end_noack", 64'(mdio_noack), 64'(!cur_resp));
              $display("read %0d: resp=%0b data=%h link_up=%0b noack=%0b",
                       read_idx, cur_resp, cur_data, link_up, mdio_noack);
              read_idx++;
              reads_done++;
            end else begin
              if (frame_idx < 2) begin
                cap_o[frame_idx] = cur_o;
                cap_t[frame_idx] = cur_t;
              end
              if (frame_idx == 1) model_init = 1'b1;
              $display("write frame %0d: bits=%h", frame_idx, cur_o);
            end
            check_eq("init_done", 64'(init_done), 64'(model_init));
            frame_idx++;
            rise_cnt = 0;
            is_read = 1'b0;
            mdio_i = 1'b1;
          end else begin
            check_eq("link_hold", 64'(link_up), 64'(model_link));
            check_eq("noack_idle", 64'(mdio_noack), 64'd0);
            if (is_read && cur_resp && rise_cnt >= 47)
              mdio_i = (rise_cnt == 47) ? 1'b0 : cur_data[63 - rise_cnt];
            else
              mdio_i = 1'b1;
          end
        end
        mdc_prev = mdc;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_nrst", 64'(eth_nrst), 64'd0);
    check_eq("rst_mdc", 64'(mdc), 64'd0);
    check_eq("rst_mdio_o", 64'(mdio_o), 64'd1);
    check_eq("rst_mdio_t", 64'(mdio_t), 64'd1);
    check_eq("rst_init", 64'(init_done), 64'd0);
    check_eq("rst_link", 64'(link_up), 64'd0);
    check_eq("rst_led", 64'(pl_led1), 64'd0);
    check_eq("rst_noack", 64'(mdio_noack), 64'd0);
    rst = 1'b0;
  endtask

  // Called right after rst is released on a falling edge.
  task automatic check_bringup();
    int n = 0;
    int n_rel = -1;
    int n_mdc = -1;
    while (n < 2000 && n_mdc < 0) begin
      @(posedge clk);
      #2;
      n++;
      if (eth_nrst && n_rel < 0) n_rel = n;
      if (mdc) n_mdc = n;
    end
    $display("bringup: nRST released after %0d cycles, first mdc rise at %0d", n_rel, n_mdc);
    check_eq("nrst_low_len", 64'(n_rel), 64'(RST_C));
    check_eq("mdc_seen", 64'(n_mdc > 0), 64'd1);
    check_eq("mdc_quiet", 64'(n_mdc >= RST_C + POST_C), 64'd1);
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frame_idx < target && t < 5000) begin
      @(posedge clk);
      #2;
      t++;
    end
    check_eq("wait_frames", 64'(frame_idx >= target), 64'd1);
  endtask

  initial begin
    plan_resp[0] = 1'b1; plan_data[0] = 16'h796D;
    plan_resp[1] = 1'b0; plan_data[1] = 16'h0000;
    plan_resp[2] = 1'b1; plan_data[2] = 16'h796D;
    plan_resp[3] = 1'b1; plan_data[3] = 16'h7969;
    for (int i = 4; i < NPLAN - 1; i++) begin
      plan_resp[i] = ($urandom_range(0, 3) != 0);
      plan_data[i] = 16'($urandom);
    end
    plan_resp[NPLAN-1] = 1'b1;
    plan_data[NPLAN-1] = 16'($urandom) | 16'h0004;

    apply_reset();
    check_bringup();
    wait_frames(2);
    check_eq("wr0_bits", cap_o[0], exp_wr0);
    check_eq("wr0_tristate", cap_t[0], 64'd0);
    check_eq("wr1_bits", cap_o[1], exp_wr1);
    check_eq("wr1_tristate", cap_t[1], 64'd0);

    begin
      int t = 0;
      while (reads_done < NPLAN && t < 20000) begin
        @(posedge clk);
        #2;
        t++;
      end
    end
    check_eq("reads_done", 64'(reads_done), 64'(NPLAN));
    check_eq("noack_count", 64'(noack_seen), 64'(exp_noack));
    check_eq("init_sticky", 64'(init_done), 64'd1);

    // Restart, then abort during bit 40 of the second write.
    apply_reset();
    check_bringup();
    begin
      int t = 0;
      while (!(frame_idx == 1 && rise_cnt >= 41) && t < 5000) begin
        @(posedge clk);
        #2;
        t++;
      end
      check_eq("reach_wr1_bit40", 64'(frame_idx == 1 && rise_cnt >= 41), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_eq("abort_nrst", 64'(eth_nrst), 64'd0);
    check_eq("abort_mdc", 64'(mdc), 64'd0);
    check_eq("abort_mdio_t", 64'(mdio_t), 64'd1);
    check_eq("abort_init", 64'(init_done), 64'd0);
    $display("abort: nRST=%0b mdc=%0b mdio_t=%0b init_done=%0b", eth_nrst, mdc, mdio_t, init_done);
    @(negedge clk);
    rst = 1'b0;
    check_bringup();
    wait_frames(1);
    check_eq("restart_wr0_bits", cap_o[0], exp_wr0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
